// File: rtl/z80_bus_fabric.sv
// Z80 SoC bus fabric: address decode, read-data return, wait states,
// boot-ROM overlay and power-on reset hold-off with heartbeat.
module z80_bus_fabric #(
  parameter int unsigned ROM_AW        = 13,
  parameter int unsigned IO_CH         = 4,
  parameter logic [7:0]  IO_BASE       = 8'h80,
  parameter int unsigned IO_SPAN_LOG2  = 1,
  parameter logic [7:0]  CTRL_PORT     = 8'h38,
  parameter int unsigned WAIT_ROM      = 0,
  parameter int unsigned WAIT_RAM      = 0,
  parameter int unsigned WAIT_IO       = 1,
  parameter int unsigned RST_HOLD_LOG2 = 23,
  parameter int unsigned HB_BIT        = 24
) (
  input  logic               clk,
  input  logic               resetn,
  output logic               cpu_resetn,
  output logic               heartbeat,
  input  logic               nMREQ,
  input  logic               nIORQ,
  input  logic               nRD,
  input  logic               nWR,
  input  logic               nM1,
  input  logic [15:0]        address,
  output logic               rom_ce,
  output logic               ram_ce,
  output logic               ram_we,
  output logic [IO_CH-1:0]   io_sel,
  output logic               io_rd,
  output logic               io_wr,
  input  logic [7:0]         rom_data,
  input  logic [7:0]         ram_data,
  input  logic [8*IO_CH-1:0] io_data,
  output logic [7:0]         cpu_di,
  output logic               nWAIT,
  output logic               rom_en
);

  localparam int unsigned CNT_W = HB_BIT + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [CNT_W-1:0] r_cnt;
  logic             r_cpu_resetn;
  logic             r_rom_en;
  logic             r_rom_f;
  logic             r_ram_f;
  logic [IO_CH-1:0] r_io_f;
  logic             r_unmap_f;
  logic             r_acc_prev;
  state_t           r_state;
  logic [2:0]       r_wcnt;

  logic             w_memrd;
  logic             w_memwr;
  logic             w_mem;
  logic             w_low;
  logic             w_ioacc;
  logic             w_io_q;
  logic [7:0]       w_port_idx;
  logic [IO_CH-1:0] w_io_sel;
  logic             w_ctrl_wr;
  logic             w_acc;
  logic             w_start;
  logic [2:0]       w_wval;
  state_t           w_state_nxt;
  logic [2:0]       w_wcnt_nxt;

  // Strobe decode; everything is held quiet until the CPU is out of reset
  assign w_memrd    = r_cpu_resetn & ~nMREQ & ~nRD;
  assign w_memwr    = r_cpu_resetn & ~nMREQ & ~nWR;
  assign w_mem      = w_memrd | w_memwr;
  assign w_low      = (32'(address) < (32'd1 << ROM_AW));
  assign w_ioacc    = r_cpu_resetn & ~nIORQ & nM1;
  assign w_io_q     = w_ioacc & ~w_mem;
  assign w_port_idx = address[7:0] >> IO_SPAN_LOG2;

  always_comb begin
    w_io_sel = '0;
    for (int k = 0; k < int'(IO_CH); k++) begin
      w_io_sel[k] = w_io_q &
                    (w_port_idx == 8'(32'(IO_BASE >> IO_SPAN_LOG2) + 32'(k)));
    end
  end

  assign rom_ce     = w_memrd & w_low & r_rom_en;
  assign ram_ce     = (w_memrd & ~(w_low & r_rom_en)) | w_memwr;
  assign ram_we     = w_memwr;
  assign io_sel     = w_io_sel;
  assign io_rd      = w_io_q & ~nRD & (|w_io_sel);
  assign io_wr      = w_io_q & ~nWR & (|w_io_sel);
  // Overlay disable bit rides on address[8] (B register of OUT (C),r)
  assign w_ctrl_wr  = w_io_q & ~nWR & (address[7:0] == CTRL_PORT) & address[8];

  assign cpu_resetn = r_cpu_resetn;
  assign heartbeat  = r_cnt[HB_BIT];
  assign rom_en     = r_rom_en;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_cpu_resetn <= 1'b0;
      r_rom_en     <= 1'b1;
      r_rom_f      <= 1'b0;
      r_ram_f      <= 1'b0;
      r_io_f       <= '0;
      r_unmap_f    <= 1'b0;
      r_acc_prev   <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + CNT_W'(1);
      r_cpu_resetn <= r_cpu_resetn | r_cnt[RST_HOLD_LOG2];
      if (!r_cpu_resetn)
        r_rom_en <= 1'b1;
      else if (w_ctrl_wr)
        r_rom_en <= 1'b0;
      r_rom_f      <= rom_ce;
      r_ram_f      <= ram_ce & w_memrd;
      r_io_f       <= w_io_sel & {IO_CH{~nRD}};
      r_unmap_f    <= w_io_q & ~nRD & ~(|w_io_sel);
      r_acc_prev   <= w_acc;
    end
  end

  // Read return: flags line up with the one-cycle synchronous memories
  always_comb begin
    cpu_di = ({8{r_rom_f}} & rom_data) | ({8{r_ram_f}} & ram_data) | {8{r_unmap_f}};
    for (int k = 0; k < int'(IO_CH); k++) begin
      cpu_di = cpu_di | ({8{r_io_f[k]}} & io_data[8*k +: 8]);
    end
  end

  assign w_acc   = w_mem | w_ioacc;
  assign w_start = w_acc & ~r_acc_prev;
  assign w_wval  = w_mem ? (rom_ce ? 3'(WAIT_ROM) : 3'(WAIT_RAM)) : 3'(WAIT_IO);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_wcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // nWAIT is low for exactly w_wval cycles, starting on the access-start cycle
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    nWAIT       = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_start && (w_wval != 3'd0)) begin
          w_state_nxt = S_WAIT;
          w_wcnt_nxt  = w_wval - 3'd1;
          nWAIT       = 1'b0;
        end
      end
      S_WAIT: begin
        nWAIT = (r_wcnt == 3'd0);
        if (!w_acc || (r_wcnt == 3'd0))
          w_state_nxt = S_IDLE;
        else
          w_wcnt_nxt = r_wcnt - 3'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_z80_bus_fabric.sv
// Directed bench for z80_bus_fabric with short hold-off and RAM wait states.
module tb_z80_bus_fabric;

  localparam int unsigned IO_CH = 4;

  logic               clk;
  logic               resetn;
  logic               cpu_resetn;
  logic               heartbeat;
  logic               nMREQ, nIORQ, nRD, nWR, nM1;
  logic [15:0]        address;
  logic               rom_ce, ram_ce, ram_we;
  logic [IO_CH-1:0]   io_sel;
  logic               io_rd, io_wr;
  logic [7:0]         rom_data, ram_data;
  logic [8*IO_CH-1:0] io_data;
  logic [7:0]         cpu_di;
  logic               nWAIT;
  logic               rom_en;

  int total = 0;
  int bad   = 0;

  z80_bus_fabric #(
    .ROM_AW(13), .IO_CH(IO_CH), .IO_BASE(8'h80), .IO_SPAN_LOG2(1),
    .CTRL_PORT(8'h38), .WAIT_ROM(0), .WAIT_RAM(3), .WAIT_IO(1),
    .RST_HOLD_LOG2(4), .HB_BIT(5)
  ) dut (
    .clk(clk), .resetn(resetn), .cpu_resetn(cpu_resetn), .heartbeat(heartbeat),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1),
    .address(address), .rom_ce(rom_ce), .ram_ce(ram_ce), .ram_we(ram_we),
    .io_sel(io_sel), .io_rd(io_rd), .io_wr(io_wr), .rom_data(rom_data),
    .ram_data(ram_data), .io_data(io_data), .cpu_di(cpu_di), .nWAIT(nWAIT),
    .rom_en(rom_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  initial begin
    resetn   = 1'b0;
    bus_idle();
    address  = 16'h0000;
    rom_data = 8'hC3;
    ram_data = 8'h5A;
    io_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    tick(); tick(); tick();

    check("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    check("rst_heartbeat",  32'(heartbeat),  32'd0);
    check("rst_nwait",      32'(nWAIT),      32'd1);
    check("rst_rom_en",     32'(rom_en),     32'd1);
    check("rst_cpu_di",     32'(cpu_di),     32'h00);
    address = 16'h0123; nMREQ = 1'b0; nRD = 1'b0; #1;
    check("rst_rom_ce_forced", 32'(rom_ce), 32'd0);
    check("rst_ram_ce_forced", 32'(ram_ce), 32'd0);
    bus_idle();

    // Release reset just after an edge; count edges from here
    resetn = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      tick();
      if (n == 16) check("hold_n16",  32'(cpu_resetn), 32'd0);
      if (n == 17) check("hold_n17",  32'(cpu_resetn), 32'd1);
      if (n == 31) check("hb_n31",    32'(heartbeat),  32'd0);
      if (n == 32) check("hb_n32",    32'(heartbeat),  32'd1);
      if (n == 63) check("hb_n63",    32'(heartbeat),  32'd1);
      if (n == 64) check("hb_n64",    32'(heartbeat),  32'd0);
    end

    // ROM read, zero wait states
    address = 16'h0123; nMREQ = 1'b0; nRD = 1'b0; #1;
    check("rom_rd_rom_ce", 32'(rom_ce), 32'd1);
    check("rom_rd_ram_ce", 32'(ram_ce), 32'd0);
    check("rom_rd_nwait",  32'(nWAIT),  32'd1);
    tick();
    check("rom_rd_di",     32'(cpu_di), 32'hC3);
    check("rom_rd_nwait1", 32'(nWAIT),  32'd1);
    bus_idle(); tick();
    check("idle_di",       32'(cpu_di), 32'h00);

    // RAM read with three wait states
    address = 16'h2000; nMREQ = 1'b0; nRD = 1'b0; #1;
    check("ram_rd_ram_ce", 32'(ram_ce), 32'd1);
    check("ram_rd_rom_ce", 32'(rom_ce), 32'd0);
    check("ram_rd_nwait0", 32'(nWAIT),  32'd0);
    tick();
    check("ram_rd_di",     32'(cpu_di), 32'h5A);
    check("ram_rd_nwait1", 32'(nWAIT),  32'd0);
    tick();
    check("ram_rd_nwait2", 32'(nWAIT),  32'd0);
    tick();
    check("ram_rd_nwait3", 32'(nWAIT),  32'd1);
    bus_idle(); tick();

    // Shadow write under the overlay; strobe dropped mid-wait
    address = 16'h0100; nMREQ = 1'b0; nWR = 1'b0; #1;
    check("shadow_ram_we", 32'(ram_we), 32'd1);
    check("shadow_ram_ce", 32'(ram_ce), 32'd1);
    check("shadow_rom_ce", 32'(rom_ce), 32'd0);
    tick();
    bus_idle();
    tick();
    check("drop_nwait", 32'(nWAIT), 32'd1);
    check("still_rom_en", 32'(rom_en), 32'd1);

    // Control write with address[8]=0 must not clear the overlay
    address = 16'h0038; nIORQ = 1'b0; nWR = 1'b0; #1;
    check("ctrl0_io_sel", 32'(io_sel), 32'h0);
    check("ctrl0_io_wr",  32'(io_wr),  32'd0);
    check("ctrl0_nwait",  32'(nWAIT),  32'd0);
    tick();
    check("ctrl0_rom_en", 32'(rom_en), 32'd1);
    check("io_wait_end",  32'(nWAIT),  32'd1);
    bus_idle(); tick();

    address = 16'h0138; nIORQ = 1'b0; nWR = 1'b0;
    tick();
    check("ctrl1_rom_en", 32'(rom_en), 32'd0);
    bus_idle(); tick();

    address = 16'h0100; nMREQ = 1'b0; nRD = 1'b0; #1;
    check("ovl_off_ram_ce", 32'(ram_ce), 32'd1);
    check("ovl_off_rom_ce", 32'(rom_ce), 32'd0);
    bus_idle(); tick(); tick();

    // Mapped I/O read on channel 1
    address = 16'h0082; nIORQ = 1'b0; nRD = 1'b0; #1;
    check("io_rd_sel",    32'(io_sel), 32'h2);
    check("io_rd_strobe", 32'(io_rd),  32'd1);
    check("io_rd_nwait0", 32'(nWAIT),  32'd0);
    tick();
    check("io_rd_nwait1", 32'(nWAIT),  32'd1);
    check("io_rd_di",     32'(cpu_di), 32'h22);
    bus_idle(); tick();

    // Unmapped I/O read
    address = 16'h0090; nIORQ = 1'b0; nRD = 1'b0; #1;
    check("unmap_sel",   32'(io_sel), 32'h0);
    check("unmap_io_rd", 32'(io_rd),  32'd0);
    tick();
    check("unmap_di",    32'(cpu_di), 32'hFF);
    bus_idle(); tick();

    // I/O write to channel 3
    address = 16'h0086; nIORQ = 1'b0; nWR = 1'b0; #1;
    check("io_wr_sel",    32'(io_sel), 32'h8);
    check("io_wr_strobe", 32'(io_wr),  32'd1);
    check("io_wr_rd",     32'(io_rd),  32'd0);
    bus_idle(); tick();

    // Interrupt acknowledge selects nothing
    address = 16'h0082; nIORQ = 1'b0; nM1 = 1'b0; #1;
    check("inta_sel",   32'(io_sel), 32'h0);
    check("inta_nwait", 32'(nWAIT),  32'd1);
    bus_idle(); tick();

    // Illegal MREQ+IORQ: memory wins
    address = 16'h0082; nMREQ = 1'b0; nIORQ = 1'b0; nRD = 1'b0; #1;
    check("illegal_sel",    32'(io_sel), 32'h0);
    check("illegal_ram_ce", 32'(ram_ce), 32'd1);
    check("illegal_io_rd",  32'(io_rd),  32'd0);
    bus_idle(); tick(); tick();

    // Reset asserted in the middle of a RAM wait
    address = 16'h3000; nMREQ = 1'b0; nRD = 1'b0;
    tick();
    check("midrst_pre_nwait", 32'(nWAIT), 32'd0);
    resetn = 1'b0;
    tick();
    check("midrst_nwait",      32'(nWAIT),      32'd1);
    check("midrst_rom_en",     32'(rom_en),     32'd1);
    check("midrst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    check("midrst_ram_ce",     32'(ram_ce),     32'd0);
    bus_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z80_bus_fabric.md
Name: z80_bus_fabric

Overview:
Parametrised bus fabric for the Z80 SoC. It takes the tv80 control strobes and address, and decodes them into a ROM region, a RAM region and IO_CH I/O channels. It also provides a registered read-data return mux, per-region wait-state generation, a software-clearable boot-ROM overlay, and the power-on reset hold-off plus heartbeat counter. It sits between the CPU core and the ROM, RAM and peripheral instances in the top level.

Parameters:
ROM_AW, 13, ROM overlay covers addresses 0 to 2^ROM_AW-1.
IO_CH, 4, number of I/O channels; power of 2, range 1..16.
IO_BASE, 8'h80, port address of channel 0; aligned to IO_CH*2^IO_SPAN_LOG2.
IO_SPAN_LOG2, 1, log2 of the ports per channel.
CTRL_PORT, 8'h38, port address of the overlay control register.
WAIT_ROM, 0, wait states per ROM access (0..7).
WAIT_RAM, 0, wait states per RAM access (0..7).
WAIT_IO, 1, wait states per I/O access (0..7).
RST_HOLD_LOG2, 23, reset hold-off is 2^RST_HOLD_LOG2 clocks.
HB_BIT, 24, counter bit driven onto heartbeat; must be >= RST_HOLD_LOG2.

Ports:
clk  in  1  system clock; all logic on rising edge.
resetn  in  1  synchronous active-low reset.
cpu_resetn  out  1  clean reset to the CPU and peripherals.
heartbeat  out  1  counter[HB_BIT].
nMREQ, nIORQ, nRD, nWR, nM1  in  1 each  CPU strobes, active low.
address  in  16  CPU address.
rom_ce  out  1  ROM read enable.
ram_ce  out  1  RAM enable.
ram_we  out  1  RAM write enable.
io_sel  out  IO_CH  one-hot channel select.
io_rd  out  1  I/O read strobe.
io_wr  out  1  I/O write strobe.
rom_data  in  8  ROM read data.
ram_data  in  8  RAM read data.
io_data  in  8*IO_CH  channel read data; channel k occupies bits [8k+7:8k].
cpu_di  out  8  read data to the CPU.
nWAIT  out  1  wait request to the CPU.
rom_en  out  1  overlay status.

Behaviour:
Reset hold-off and heartbeat:
- Counter is HB_BIT+1 bits wide. It clears while resetn=0 and increments every clock afterwards, wrapping freely.
- cpu_resetn goes to 1 on the clock after counter[RST_HOLD_LOG2] first reads 1. It stays 1 until resetn falls.
- Asserting resetn mid-operation: on the next edge, cpu_resetn=0 and all state returns to reset values.

Reset values:
- cpu_resetn=0, heartbeat=0, nWAIT=1, rom_en=1, cpu_di=8'h00.
- All registered selects = 0.
- While cpu_resetn=0, all decode outputs are forced to 0.

Decode (combinational, qualified by cpu_resetn):
- memrd = ~nMREQ & ~nRD; memwr = ~nMREQ & ~nWR.
- Address is "low" when address < 2^ROM_AW.
- rom_ce = memrd & low & rom_en.
- ram_ce = (memrd & ~(low & rom_en)) | memwr.
- ram_we = memwr. Writes into the overlay window always reach the RAM underneath (shadow copy).
- ioacc = ~nIORQ & nM1. Interrupt acknowledge (nM1=0) selects nothing.
- io_sel[k] = ioacc & (address[7:0] >> IO_SPAN_LOG2) == (IO_BASE >> IO_SPAN_LOG2) + k.
- io_rd = ioacc & ~nRD & |io_sel; io_wr = ioacc & ~nWR & |io_sel.
- nMREQ and nIORQ both low is illegal. Memory decode wins and io_sel is forced to 0.

Overlay control:
- An I/O write to address[7:0]==CTRL_PORT with data bit0=1 clears rom_en.
- The fabric samples data bit0 from a dedicated din? No: the data bit is taken from address[8]. Software executes OUT (C),r with B=1; this keeps the block free of a data-bus input.
- rom_en is restored to 1 only by resetn or cpu_resetn=0. Writes with address[8]=0 have no effect.

Read return:
- One registered flag per source (rom, ram, each io channel) plus an "unmapped I/O read" flag, captured every clock: 1-cycle latency, matching the synchronous ROM/RAM.
- cpu_di = OR over the registered flags of (flag AND source data).
- Unmapped I/O read returns 8'hFF. Unmapped memory reads cannot occur; the two regions cover the full 64 KB.
- No flag set gives cpu_di=8'h00.

Wait-state generator:
- States: IDLE and WAIT, with a 3-bit down counter.
- An access start is a cycle where (memrd|memwr|ioacc) is 1 and was 0 on the previous cycle.
- On an access start, load the counter with the region's WAIT_* value. If that value is nonzero, go to WAIT with nWAIT=0 on the same cycle (combinational from the start condition).
- In WAIT, nWAIT=0 and the counter decrements each clock. On reaching 0, return to IDLE and drive nWAIT=1.
- A WAIT value of 0 never drops nWAIT.
- If the strobe deasserts during WAIT, go to IDLE and release nWAIT on the next clock.
- Back-to-back accesses without a gap in the strobe count as one access.

Test Plan:
- Hold-off: sim with RST_HOLD_LOG2=4, HB_BIT=5; release resetn -> cpu_resetn rises exactly 17 clocks later, and heartbeat toggles every 32 clocks.
- ROM read at 16'h0123 with rom_data=8'hC3 -> rom_ce=1, ram_ce=0, and cpu_di=8'hC3 one clock later. RAM read at 16'h2000 with ram_data=8'h5A -> cpu_di=8'h5A.
- Write to 16'h0100 while rom_en=1 -> ram_we=1, rom_ce=0.
- OUT to port 16'h0138 -> rom_en=0. A subsequent read at 16'h0100 -> ram_ce=1, rom_ce=0.
- Port read at 16'h0082 -> io_sel=4'b0010 with channel 1 data returned. Port read at 16'h0090 -> io_sel=0 and cpu_di=8'hFF. nM1=0 with nIORQ=0 -> io_sel=0.
- WAIT_IO=1: I/O access -> nWAIT low for exactly 1 cycle. WAIT_RAM=3 with the strobe dropped after 1 cycle -> nWAIT high on the next clock. resetn low mid-wait -> nWAIT=1 and rom_en=1 next clock.
